// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester handshake, engine handshake and 68k bus signals of the arbiter
interface bus_arbiter_if;
    logic       MC_CLK_FALLING;
    logic [1:0] REQ_VALID;
    logic [1:0] REQ_ACK;
    logic [1:0] REQ_DONE;
    logic [1:0] GNT;
    logic       ENG_START;
    logic       ENG_DONE;
    logic       nBG_IN;
    logic       nAS_IN;
    logic       nDTACK_IN;
    logic       nBGACK_IN;
    logic       BR_DRIVE;
    logic       BGACK_DRIVE;
    logic       BM_ACTIVE;
    logic       TIMEOUT;
    logic       TIMEOUT_CLR;
    modport master (
        input  MC_CLK_FALLING, REQ_VALID, ENG_DONE, nBG_IN, nAS_IN, nDTACK_IN, nBGACK_IN, TIMEOUT_CLR,
        output REQ_ACK, REQ_DONE, GNT, ENG_START, BR_DRIVE, BGACK_DRIVE, BM_ACTIVE, TIMEOUT
    );
    modport slave (
        output MC_CLK_FALLING, REQ_VALID, ENG_DONE, nBG_IN, nAS_IN, nDTACK_IN, nBGACK_IN, TIMEOUT_CLR,
        input  REQ_ACK, REQ_DONE, GNT, ENG_START, BR_DRIVE, BGACK_DRIVE, BM_ACTIVE, TIMEOUT
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: 68k bus-master acquisition with round-robin arbitration of two engine requesters
module bus_arbiter #(
    parameter int HOLD_CYCLES = 8,
    parameter int BG_TIMEOUT  = 1023
) (
    input logic SYSCLK,
    input logic RESET,
    bus_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ_BUS, WAIT_FREE, OWN, RUN, HOLD, RELEASE} state_t;
    localparam int CMAX = BG_TIMEOUT > HOLD_CYCLES ? BG_TIMEOUT : HOLD_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] sync_q, sync_d;
    logic [1:0] gnt_q, gnt_d, ack_q, ack_d, win;
    logic start_q, start_d, ptr_q, ptr_d, tout_q, tout_d;
    logic done_ok, nbg_s, bus_free, owned;
    assign nbg_s    = sync_q[7];
    assign bus_free = &sync_q[6:4];
    always_comb begin
        sync_d  = {sync_q[3:0], bus.nBG_IN, bus.nAS_IN, bus.nDTACK_IN, bus.nBGACK_IN};
        // engine cannot finish in its own start cycle, keeping ACK and DONE apart
        done_ok = state_q == RUN && bus.ENG_DONE && !start_q;
        win     = &bus.REQ_VALID ? (ptr_q ? 2'b10 : 2'b01) : bus.REQ_VALID;
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ack_d   = 2'b00;
        start_d = 1'b0;
        ptr_d   = ptr_q;
        tout_d  = tout_q & ~bus.TIMEOUT_CLR;
        case (state_q)
            IDLE: if (|bus.REQ_VALID) begin
                state_d = REQ_BUS;
                cnt_d   = '0;
            end
            REQ_BUS: if (!nbg_s) state_d = WAIT_FREE;
                else if (cnt_q == CW'(BG_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    tout_d  = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            WAIT_FREE: if (bus.MC_CLK_FALLING && bus_free) state_d = OWN;
            OWN: if (|bus.REQ_VALID) begin
                state_d = RUN;
                gnt_d   = win;
                ack_d   = win;
                start_d = 1'b1;
            end else begin
                state_d = HOLD;
                cnt_d   = CW'(HOLD_CYCLES - 1);
            end
            RUN: if (done_ok) begin
                state_d = OWN;
                gnt_d   = 2'b00;
                ptr_d   = gnt_q[0];
            end
            HOLD: if (|bus.REQ_VALID) state_d = OWN;
                else if (cnt_q == '0) state_d = RELEASE;
                else cnt_d = cnt_q - 1'b1;
            RELEASE: if (bus.MC_CLK_FALLING) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sync_q  <= '1;
            gnt_q   <= 2'b00;
            ack_q   <= 2'b00;
            start_q <= 1'b0;
            ptr_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            ptr_q   <= ptr_d;
            tout_q  <= tout_d;
        end
    end
    assign owned           = state_q inside {OWN, RUN, HOLD, RELEASE};
    assign bus.GNT         = gnt_q;
    assign bus.REQ_ACK     = ack_q;
    assign bus.ENG_START   = start_q;
    assign bus.REQ_DONE    = done_ok && !RESET ? gnt_q : 2'b00;
    assign bus.BR_DRIVE    = state_q == REQ_BUS || state_q == WAIT_FREE;
    assign bus.BGACK_DRIVE = owned;
    assign bus.BM_ACTIVE   = owned;
    assign bus.TIMEOUT     = tout_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of acquisition, arbitration, hold, release, timeout and reset
module tb_bus_arbiter;
    logic SYSCLK = 1'b0;
    logic RESET;
    int n_chk = 0;
    int n_fail = 0;
    bus_arbiter_if bus ();
    bus_arbiter dut (.SYSCLK(SYSCLK), .RESET(RESET), .bus(bus));
    always #5 SYSCLK = ~SYSCLK;

    task automatic step(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_br"}, bus.BR_DRIVE, 1'b0);
        chk({tag, "_bgack"}, bus.BGACK_DRIVE, 1'b0);
        chk({tag, "_bm"}, bus.BM_ACTIVE, 1'b0);
        chk({tag, "_gnt"}, bus.GNT, 2'b00);
        chk({tag, "_ack"}, bus.REQ_ACK, 2'b00);
        chk({tag, "_start"}, bus.ENG_START, 1'b0);
        chk({tag, "_done"}, bus.REQ_DONE, 2'b00);
        chk({tag, "_tout"}, bus.TIMEOUT, 1'b0);
    endtask

    task automatic run_cycle(input logic [1:0] g, input string tag);
        int k = 0;
        while (!bus.ENG_START && k < 50) begin
            step(1);
            k++;
        end
        chk({tag, "_start"}, bus.ENG_START, 1'b1);
        chk({tag, "_ack"}, bus.REQ_ACK, g);
        chk({tag, "_gnt"}, bus.GNT, g);
        step(1);
        chk({tag, "_gnt_held"}, bus.GNT, g);
        bus.ENG_DONE = 1'b1;
        #1;
        chk({tag, "_done"}, bus.REQ_DONE, g);
        step(1);
        bus.ENG_DONE = 1'b0;
        chk({tag, "_gap"}, bus.ENG_START, 1'b0);
        chk({tag, "_gnt_off"}, bus.GNT, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1;
        bus.MC_CLK_FALLING = 1'b0;
        bus.REQ_VALID = 2'b00;
        bus.ENG_DONE = 1'b0;
        bus.nBG_IN = 1'b1;
        bus.nAS_IN = 1'b1;
        bus.nDTACK_IN = 1'b1;
        bus.nBGACK_IN = 1'b1;
        bus.TIMEOUT_CLR = 1'b0;
        step(3);
        chk_idle_outputs("rst");
        RESET = 1'b0;
        // single request, grant after 20 cycles, free bus
        bus.REQ_VALID = 2'b01;
        step(1);
        chk("s_br", bus.BR_DRIVE, 1'b1);
        chk("s_bgack0", bus.BGACK_DRIVE, 1'b0);
        step(19);
        bus.nBG_IN = 1'b0;
        chk("s_br_held", bus.BR_DRIVE, 1'b1);
        step(5);
        chk("s_br_wait", bus.BR_DRIVE, 1'b1);
        chk("s_bgack_wait", bus.BGACK_DRIVE, 1'b0);
        bus.MC_CLK_FALLING = 1'b1;
        step(1);
        bus.MC_CLK_FALLING = 1'b0;
        chk("s_bgack", bus.BGACK_DRIVE, 1'b1);
        chk("s_br_off", bus.BR_DRIVE, 1'b0);
        chk("s_bm", bus.BM_ACTIVE, 1'b1);
        chk("s_nostart", bus.ENG_START, 1'b0);
        step(1);
        chk("s_ack", bus.REQ_ACK, 2'b01);
        chk("s_start", bus.ENG_START, 1'b1);
        chk("s_gnt", bus.GNT, 2'b01);
        bus.REQ_VALID = 2'b00;
        step(1);
        chk("s_start_off", bus.ENG_START, 1'b0);
        chk("s_ack_off", bus.REQ_ACK, 2'b00);
        chk("s_gnt_held", bus.GNT, 2'b01);
        bus.ENG_DONE = 1'b1;
        #1;
        chk("s_done", bus.REQ_DONE, 2'b01);
        step(1);
        bus.ENG_DONE = 1'b0;
        #1;
        chk("s_gnt_off", bus.GNT, 2'b00);
        chk("s_done_off", bus.REQ_DONE, 2'b00);
        step(1);
        bus.MC_CLK_FALLING = 1'b1;
        chk("s_hold_bm", bus.BM_ACTIVE, 1'b1);
        step(8);
        chk("s_release_bm", bus.BM_ACTIVE, 1'b1);
        step(1);
        chk("s_released_bm", bus.BM_ACTIVE, 1'b0);
        chk("s_released_bgack", bus.BGACK_DRIVE, 1'b0);
        bus.MC_CLK_FALLING = 1'b0;
        // contention from a reset pointer
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        bus.MC_CLK_FALLING = 1'b1;
        bus.REQ_VALID = 2'b11;
        run_cycle(2'b01, "c1");
        run_cycle(2'b10, "c2");
        run_cycle(2'b01, "c3");
        run_cycle(2'b10, "c4");
        bus.REQ_VALID = 2'b00;
        bus.MC_CLK_FALLING = 1'b0;
        // new request three cycles into HOLD reuses the bus
        step(1);
        chk("h_hold_bm", bus.BM_ACTIVE, 1'b1);
        step(3);
        bus.REQ_VALID = 2'b10;
        step(1);
        chk("h_own_br", bus.BR_DRIVE, 1'b0);
        chk("h_own_bm", bus.BM_ACTIVE, 1'b1);
        step(1);
        chk("h_start", bus.ENG_START, 1'b1);
        chk("h_gnt", bus.GNT, 2'b10);
        chk("h_br", bus.BR_DRIVE, 1'b0);
        bus.REQ_VALID = 2'b00;
        step(1);
        bus.ENG_DONE = 1'b1;
        #1;
        chk("h_done", bus.REQ_DONE, 2'b10);
        step(1);
        bus.ENG_DONE = 1'b1;
        #1;
        chk("h_stray_done", bus.REQ_DONE, 2'b00);
        step(1);
        bus.ENG_DONE = 1'b0;
        bus.MC_CLK_FALLING = 1'b1;
        for (int k = 0; k < 20 && bus.BM_ACTIVE; k++) step(1);
        chk("h_released", bus.BM_ACTIVE, 1'b0);
        bus.MC_CLK_FALLING = 1'b0;
        // busy bus: nAS low for three strobes
        bus.nAS_IN = 1'b0;
        bus.REQ_VALID = 2'b01;
        step(4);
        chk("b_br", bus.BR_DRIVE, 1'b1);
        chk("b_bgack0", bus.BGACK_DRIVE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.MC_CLK_FALLING = 1'b1;
            step(1);
            bus.MC_CLK_FALLING = 1'b0;
            chk("b_busy_bgack", bus.BGACK_DRIVE, 1'b0);
            step(2);
        end
        bus.nAS_IN = 1'b1;
        step(3);
        chk("b_nostrobe_bgack", bus.BGACK_DRIVE, 1'b0);
        bus.MC_CLK_FALLING = 1'b1;
        step(1);
        bus.MC_CLK_FALLING = 1'b0;
        chk("b_bgack", bus.BGACK_DRIVE, 1'b1);
        chk("b_br_off", bus.BR_DRIVE, 1'b0);
        step(1);
        chk("b_start", bus.ENG_START, 1'b1);
        chk("b_ack", bus.REQ_ACK, 2'b01);
        bus.REQ_VALID = 2'b00;
        step(1);
        chk("b_gnt", bus.GNT, 2'b01);
        // reset in the middle of RUN
        bus.nBG_IN = 1'b1;
        RESET = 1'b1;
        bus.ENG_DONE = 1'b1;
        #1;
        chk("r_done_in_reset", bus.REQ_DONE, 2'b00);
        step(1);
        RESET = 1'b0;
        bus.ENG_DONE = 1'b0;
        #1;
        chk_idle_outputs("r");
        bus.ENG_DONE = 1'b1;
        #1;
        chk("r_late_done", bus.REQ_DONE, 2'b00);
        step(1);
        bus.ENG_DONE = 1'b0;
        chk("r_gnt", bus.GNT, 2'b00);
        chk("r_bm", bus.BM_ACTIVE, 1'b0);
        // grant timeout with nBG held high
        bus.REQ_VALID = 2'b01;
        step(1);
        bus.REQ_VALID = 2'b00;
        chk("t_br", bus.BR_DRIVE, 1'b1);
        step(1022);
        chk("t_br_last", bus.BR_DRIVE, 1'b1);
        chk("t_tout_pre", bus.TIMEOUT, 1'b0);
        step(1);
        chk("t_br_off", bus.BR_DRIVE, 1'b0);
        chk("t_tout", bus.TIMEOUT, 1'b1);
        chk("t_ack", bus.REQ_ACK, 2'b00);
        step(3);
        chk("t_sticky", bus.TIMEOUT, 1'b1);
        bus.TIMEOUT_CLR = 1'b1;
        step(1);
        bus.TIMEOUT_CLR = 1'b0;
        chk("t_clr", bus.TIMEOUT, 1'b0);
        // set and clear in the same cycle: set wins
        bus.REQ_VALID = 2'b01;
        step(1);
        bus.REQ_VALID = 2'b00;
        step(1022);
        bus.TIMEOUT_CLR = 1'b1;
        step(1);
        bus.TIMEOUT_CLR = 1'b0;
        chk("t_set_wins", bus.TIMEOUT, 1'b1);
        chk("t_br_off2", bus.BR_DRIVE, 1'b0);
        bus.TIMEOUT_CLR = 1'b1;
        step(1);
        bus.TIMEOUT_CLR = 1'b0;
        chk("t_clr2", bus.TIMEOUT, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 8: SYSCLK cycles the bus stays owned with no pending request before release.
REQ-002 Parameter BG_TIMEOUT, default 1023: SYSCLK cycles to wait for bus grant before aborting.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
- SYSCLK  in  1  system clock, PLL output.
- RESET  in  1  synchronous, active-high.
REQ-004 Ports:
- MC_CLK_FALLING  in  1  one-SYSCLK strobe at each 7M falling edge.
- REQ_VALID  in  2  per-requester cycle request; bit0 = Pi port, bit1 = internal requester.
- REQ_ACK  out  2  one-hot, one-cycle pulse when the request is accepted.
- REQ_DONE  out  2  one-hot, one-cycle pulse when that requester's engine cycle completes.
- GNT  out  2  one-hot mux select; stable from ACK through DONE.
- ENG_START  out  1  one-cycle start pulse to the bus-cycle engine.
- ENG_DONE  in  1  one-cycle completion pulse from the engine.
- nBG_IN, nAS_IN, nDTACK_IN, nBGACK_IN  in  1 each  raw 68k bus inputs.
- BR_DRIVE  out  1  drive nBR low.
- BGACK_DRIVE  out  1  drive nBGACK low.
- BM_ACTIVE  out  1  high while the bus is owned.
- TIMEOUT  out  1  sticky grant-timeout flag.
- TIMEOUT_CLR  in  1  clears TIMEOUT.

Function
REQ-005 The four raw bus inputs SHALL pass through 2-flop synchronizers on SYSCLK; all FSM decisions use the synchronized values.
REQ-006 States: IDLE, REQ_BUS, WAIT_FREE, OWN, RUN, HOLD, RELEASE.
REQ-007 IDLE: when any REQ_VALID bit is high, go to REQ_BUS next cycle and assert BR_DRIVE.
REQ-008 REQ_BUS:
- BR_DRIVE high; the timeout counter increments each cycle.
- Synchronized nBG low: go to WAIT_FREE.
- Counter reaches BG_TIMEOUT: drop BR_DRIVE, set TIMEOUT, return to IDLE.
REQ-009 WAIT_FREE: on the first MC_CLK_FALLING with synchronized nAS, nDTACK and nBGACK all high, assert BGACK_DRIVE, deassert BR_DRIVE in the same cycle, and go to OWN.
REQ-010 OWN: BM_ACTIVE high.
- Any request pending: select a winner per REQ-011, pulse REQ_ACK[winner], set GNT, pulse ENG_START in the same cycle, go to RUN.
- Otherwise: go to HOLD.
REQ-011 Arbitration SHALL be round-robin using a last-granted pointer.
- If both requests are pending, grant the requester not granted last.
- After reset the pointer favours bit0.
REQ-012 RUN:
- GNT held; ENG_START low.
- On ENG_DONE, pulse REQ_DONE[GNT], update the pointer, return to OWN.
- REQ_VALID changes during RUN are ignored until OWN.
REQ-013 Back-to-back: OWN re-arbitrates the cycle after RUN exits, giving a 1-cycle minimum gap between ENG_DONE and the next ENG_START.
REQ-014 HOLD: the counter loads HOLD_CYCLES-1 on entry.
- Any new request: return to OWN without releasing the bus.
- Counter reaches 0: go to RELEASE.
REQ-015 RELEASE:
- Deassert BGACK_DRIVE and BM_ACTIVE on the next MC_CLK_FALLING, then go to IDLE.
- A request arriving in RELEASE SHALL NOT cancel the release; it is serviced from IDLE afterwards.
REQ-016 Invariants:
- GNT is 2'b00 outside RUN.
- BR_DRIVE and BGACK_DRIVE are never both high for more than the single WAIT_FREE exit cycle.
- REQ_ACK and REQ_DONE never pulse for the same requester in the same cycle.
REQ-017 TIMEOUT:
- Sticky; cleared by TIMEOUT_CLR or RESET.
- Set and clear in the same cycle: set wins.
REQ-018 ENG_DONE arriving outside RUN SHALL be ignored.

Reset
REQ-019 Under RESET the FSM SHALL be in IDLE, and the following SHALL be 0: GNT, REQ_ACK, REQ_DONE, ENG_START, BR_DRIVE, BGACK_DRIVE, BM_ACTIVE, TIMEOUT, the counters and the RR pointer.
REQ-020 RESET during RUN SHALL abandon the engine cycle; no REQ_DONE is issued and the bus is dropped immediately, without waiting for MC_CLK_FALLING.
REQ-021 Synchronizer flops SHALL reset to 1 (bus-inactive levels).

Verification
REQ-022 Single request: REQ_VALID=01, nBG low after 20 cycles, bus idle -> BR_DRIVE then BGACK_DRIVE at the next MC_CLK_FALLING; REQ_ACK=01 with ENG_START; ENG_DONE -> REQ_DONE=01; release after 8 idle cycles.
REQ-023 Contention: REQ_VALID=11 held for 4 engine cycles -> grant order 01,10,01,10; never two consecutive grants to one requester.
REQ-024 Timeout: nBG held high -> BR_DRIVE drops after 1023 cycles, TIMEOUT=1, no ACK; TIMEOUT_CLR -> TIMEOUT=0.
REQ-025 Busy bus: nBG low while nAS low for 3 MC_CLK_FALLING strobes -> BGACK_DRIVE asserted only at the first strobe with nAS high.
REQ-026 Hold reuse: new request 3 cycles into HOLD -> served without BR_DRIVE re-asserting.
REQ-027 Reset mid-RUN: RESET pulse -> all outputs 0 next cycle, no REQ_DONE; a later ENG_DONE is ignored.
